// File: rtl/pmem_burst_bridge.sv
// pmem_burst_bridge
//   Splits each 128-bit Wishbone line transfer into two in-order 64-bit beats
//   on a request/grant burst memory port. Read beats are reassembled into a
//   full line before a single-cycle ACK.
//
// Ports
//   clk, rst_n   : clock (rising edge), asynchronous active-low reset
//   wb_cyc/stb   : Wishbone cycle / strobe
//   wb_we        : 1 = write line, 0 = read line
//   wb_sel       : per-byte enables for the line
//   wb_adr       : line address
//   wb_dat_m     : write line data
//   wb_dat_s     : read line data, valid while wb_ack = 1
//   wb_ack       : one-cycle completion pulse
//   wb_rty       : retry, never asserted
//   mem_req      : beat request valid
//   mem_we       : beat is a write
//   mem_addr     : beat address {line address, beat index}
//   mem_wdata    : write beat data
//   mem_wmask    : write beat byte mask
//   mem_gnt      : beat accepted while mem_req = 1
//   mem_rvalid   : read beat returned, in request order
//   mem_rdata    : read beat data
module pmem_burst_bridge #(
   parameter int LINE_ADR_W = 12
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wb_cyc,
   input  logic                  wb_stb,
   input  logic                  wb_we,
   input  logic [15:0]           wb_sel,
   input  logic [LINE_ADR_W-1:0] wb_adr,
   input  logic [127:0]          wb_dat_m,
   output logic [127:0]          wb_dat_s,
   output logic                  wb_ack,
   output logic                  wb_rty,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [LINE_ADR_W:0]   mem_addr,
   output logic [63:0]           mem_wdata,
   output logic [7:0]            mem_wmask,
   input  logic                  mem_gnt,
   input  logic                  mem_rvalid,
   input  logic [63:0]           mem_rdata
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_REQ0  = 3'd1,
      ST_REQ1  = 3'd2,
      ST_RWAIT = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   state_t                state_r;
   logic [LINE_ADR_W-1:0] adr_r;
   logic                  we_r;
   logic [15:0]           sel_r;
   logic [127:0]          dat_r;
   logic                  rcnt_r;
   logic [63:0]           line_lo_r;

   // Retry is never signalled.
   assign wb_rty = 1'b0;

   // Transfer sequencer: holding registers, beat issue, read reassembly and ACK.
   // Every memory-side output is loaded on the edge that enters the state it
   // belongs to, so outputs are pure flops with no input-to-output path.
   // A write beat with an all-zero mask is loaded with mem_req = 0, which lets
   // the owning state fall through in one cycle without waiting for a grant.
   // The ACK flop takes wb_cyc on the edge entering DONE, so a master that has
   // dropped CYC by then never sees the pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= ST_IDLE;
         adr_r     <= {LINE_ADR_W{1'b0}};
         we_r      <= 1'b0;
         sel_r     <= 16'h0000;
         dat_r     <= 128'd0;
         rcnt_r    <= 1'b0;
         line_lo_r <= 64'd0;
         wb_dat_s  <= 128'd0;
         wb_ack    <= 1'b0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= {(LINE_ADR_W + 1){1'b0}};
         mem_wdata <= 64'd0;
         mem_wmask <= 8'h00;
      end else begin
         case (state_r)
            ST_IDLE: begin
               wb_ack <= 1'b0;
               if (wb_cyc && wb_stb) begin
                  adr_r    <= wb_adr;
                  we_r     <= wb_we;
                  sel_r    <= wb_sel;
                  dat_r    <= wb_dat_m;
                  rcnt_r   <= 1'b0;
                  mem_addr <= {wb_adr, 1'b0};
                  if (wb_we) begin
                     mem_req   <= |wb_sel[7:0];
                     mem_we    <= |wb_sel[7:0];
                     mem_wdata <= wb_dat_m[63:0];
                     mem_wmask <= wb_sel[7:0];
                  end else begin
                     mem_req   <= 1'b1;
                     mem_we    <= 1'b0;
                     mem_wdata <= 64'd0;
                     mem_wmask <= 8'h00;
                  end
                  state_r <= ST_REQ0;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_REQ0: begin
               if (!mem_req || mem_gnt) begin
                  mem_addr <= {adr_r, 1'b1};
                  if (we_r) begin
                     mem_req   <= |sel_r[15:8];
                     mem_we    <= |sel_r[15:8];
                     mem_wdata <= dat_r[127:64];
                     mem_wmask <= sel_r[15:8];
                  end else begin
                     mem_req   <= 1'b1;
                     mem_we    <= 1'b0;
                  end
                  state_r <= ST_REQ1;
               end else begin
                  state_r <= ST_REQ0;
               end
            end
            ST_REQ1: begin
               // Beat 0 may come back while beat 1 is still being requested.
               if (!we_r && mem_rvalid && !rcnt_r) begin
                  line_lo_r <= mem_rdata;
                  rcnt_r    <= 1'b1;
               end else begin
                  rcnt_r    <= rcnt_r;
               end
               if (!mem_req || mem_gnt) begin
                  mem_req <= 1'b0;
                  mem_we  <= 1'b0;
                  if (we_r) begin
                     wb_ack  <= wb_cyc;
                     state_r <= ST_DONE;
                  end else begin
                     state_r <= ST_RWAIT;
                  end
               end else begin
                  state_r <= ST_REQ1;
               end
            end
            ST_RWAIT: begin
               if (mem_rvalid) begin
                  if (!rcnt_r) begin
                     line_lo_r <= mem_rdata;
                     rcnt_r    <= 1'b1;
                     state_r   <= ST_RWAIT;
                  end else begin
                     wb_dat_s <= {mem_rdata, line_lo_r};
                     rcnt_r   <= 1'b0;
                     wb_ack   <= wb_cyc;
                     state_r  <= ST_DONE;
                  end
               end else begin
                  state_r <= ST_RWAIT;
               end
            end
            ST_DONE: begin
               // STB is deliberately not looked at here.
               wb_ack  <= 1'b0;
               state_r <= ST_IDLE;
            end
            default: begin
               wb_ack  <= 1'b0;
               mem_req <= 1'b0;
               mem_we  <= 1'b0;
               rcnt_r  <= 1'b0;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pmem_burst_bridge.sv
// Testbench for pmem_burst_bridge: directed and random line transfers against
// a behavioural memory with programmable grant stalls and read latency, and a
// line-level reference memory updated from the Wishbone transactions.
module tb_pmem_burst_bridge;

   localparam int AW = 12;

   logic          clk;
   logic          rst_n;
   logic          wb_cyc;
   logic          wb_stb;
   logic          wb_we;
   logic [15:0]   wb_sel;
   logic [AW-1:0] wb_adr;
   logic [127:0]  wb_dat_m;
   logic [127:0]  wb_dat_s;
   logic          wb_ack;
   logic          wb_rty;
   logic          mem_req;
   logic          mem_we;
   logic [AW:0]   mem_addr;
   logic [63:0]   mem_wdata;
   logic [7:0]    mem_wmask;
   logic          mem_gnt;
   logic          mem_rvalid;
   logic [63:0]   mem_rdata;

   pmem_burst_bridge #(.LINE_ADR_W(AW)) dut (
      .clk(clk), .rst_n(rst_n),
      .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_sel(wb_sel),
      .wb_adr(wb_adr), .wb_dat_m(wb_dat_m), .wb_dat_s(wb_dat_s),
      .wb_ack(wb_ack), .wb_rty(wb_rty),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_gnt(mem_gnt),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input logic [127:0] obs, input logic [127:0] exp, input string tag);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Power-on memory image; line 0A3 carries a recognisable pattern.
   function automatic logic [63:0] init_word(input int i);
      if (i == 'h146) return 64'h1111_1111_1111_1111;
      if (i == 'h147) return 64'h2222_2222_2222_2222;
      return {32'(i) * 32'h9E37_79B9, ~(32'(i) * 32'h85EB_CA6B)};
   endfunction

   typedef struct { logic [12:0] a; logic [63:0] d; logic [7:0] m; } wbeat_t;
   typedef struct { int due; logic [63:0] d; } ret_t;

   // Memory-side state (written only by the responder).
   logic [63:0]  mem [0:8191];
   wbeat_t       wr_seen[$];
   logic [12:0]  rd_seen[$];
   ret_t         pend[$];
   int           cyc_n = 0;
   int           stall_left = 0;
   logic         req_p = 1'b0;
   logic         we_p = 1'b0;
   logic [12:0]  addr_p = 13'd0;
   logic [63:0]  wd_p = 64'd0;
   logic [7:0]   wm_p = 8'h00;

   // Knobs set by the stimulus for the current transfer.
   int s0_g = 0;
   int s1_g = 0;
   int lat_g = 1;

   // Reference line memory (written only by the stimulus block).
   logic [63:0] ref_mem [0:8191];

   // Behavioural burst memory: grants, stalls, in-order read returns.
   initial begin : responder
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata  = 64'd0;
      for (int i = 0; i < 8192; i++) mem[i] = init_word(i);
      forever begin
         @(negedge clk);
         cyc_n++;
         if (!rst_n) begin
            pend.delete();
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
            req_p      = 1'b0;
            stall_left = 0;
         end else begin
            if (req_p && mem_gnt) begin
               if (we_p) begin
                  wr_seen.push_back('{addr_p, wd_p, wm_p});
                  for (int b = 0; b < 8; b++)
                     if (wm_p[b]) mem[addr_p][8*b +: 8] = wd_p[8*b +: 8];
               end else begin
                  rd_seen.push_back(addr_p);
                  pend.push_back('{cyc_n + lat_g - 1, mem[addr_p]});
               end
            end
            if (req_p && !mem_gnt)
               chk({mem_req, mem_we, mem_addr, mem_wmask, mem_wdata},
                   {1'b1, we_p, addr_p, wm_p, wd_p}, "stall_hold");
            mem_rvalid = 1'b0;
            mem_rdata  = {$urandom, $urandom};
            if (pend.size() > 0 && pend[0].due <= cyc_n) begin
               mem_rvalid = 1'b1;
               mem_rdata  = pend[0].d;
               void'(pend.pop_front());
            end
            if (mem_req) begin
               if (!(req_p && !mem_gnt)) stall_left = mem_addr[0] ? s1_g : s0_g;
               if (stall_left > 0) begin
                  mem_gnt = 1'b0;
                  stall_left--;
               end else begin
                  mem_gnt = 1'b1;
               end
            end else begin
               mem_gnt = 1'b0;
            end
            req_p  = mem_req;
            we_p   = mem_we;
            addr_p = mem_addr;
            wd_p   = mem_wdata;
            wm_p   = mem_wmask;
         end
      end
   end

   // One line transfer, called at a negedge. Returns at the negedge after ACK.
   task automatic run_xfer(input logic we, input logic [11:0] adr, input logic [15:0] sel,
                           input logic [127:0] dat, input int s0, input int s1, input int lat,
                           input logic chain, input string tag);
      wbeat_t       exp_w[$];
      logic [12:0]  exp_r[$];
      logic [127:0] exp_line = 128'd0;
      logic [127:0] line_obs = 128'd0;
      int           exp_lat;
      int           lat_obs = 0;
      logic         got = 1'b0;
      int           wb0 = wr_seen.size();
      int           rb0 = rd_seen.size();
      int           nw;
      int           nr;
      s0_g = s0; s1_g = s1; lat_g = lat;
      if (we) begin
         exp_lat = 3;
         for (int h = 0; h < 2; h++) begin
            logic [12:0] a = 13'(adr) * 13'd2 + 13'(h);
            logic [7:0]  m = sel[8*h +: 8];
            if (m != 8'h00) begin
               exp_w.push_back('{a, dat[64*h +: 64], m});
               exp_lat += (h == 0) ? s0 : s1;
               for (int b = 0; b < 8; b++)
                  if (m[b]) ref_mem[a][8*b +: 8] = dat[64*h + 8*b +: 8];
            end
         end
      end else begin
         exp_r.push_back(13'(adr) * 13'd2);
         exp_r.push_back(13'(adr) * 13'd2 + 13'd1);
         exp_line = {ref_mem[exp_r[1]], ref_mem[exp_r[0]]};
         exp_lat  = 3 + s0 + s1 + lat;
      end
      wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_adr = adr; wb_sel = sel; wb_dat_m = dat;
      for (int k = 1; k <= 60; k++) begin
         @(negedge clk);
         if (wb_ack === 1'b1) begin
            got = 1'b1; lat_obs = k; line_obs = wb_dat_s;
            break;
         end
      end
      chk(got, 1'b1, {tag, " ack_seen"});
      if (got) begin
         chk(lat_obs, exp_lat, {tag, " ack_latency"});
         if (!we) chk(line_obs, exp_line, {tag, " read_line"});
      end
      if (!chain) begin
         wb_cyc = 1'b0; wb_stb = 1'b0;
      end
      @(negedge clk);
      chk(wb_ack, 1'b0, {tag, " ack_one_cycle"});
      nw = wr_seen.size() - wb0;
      nr = rd_seen.size() - rb0;
      chk(nw, exp_w.size(), {tag, " write_beats"});
      chk(nr, exp_r.size(), {tag, " read_beats"});
      for (int i = 0; i < nw && i < exp_w.size(); i++)
         chk({wr_seen[wb0+i].a, wr_seen[wb0+i].d, wr_seen[wb0+i].m},
             {exp_w[i].a, exp_w[i].d, exp_w[i].m}, {tag, " write_beat"});
      for (int i = 0; i < nr && i < exp_r.size(); i++)
         chk(rd_seen[rb0+i], exp_r[i], {tag, " read_addr"});
   endtask

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      int acks;
      int rb0;
      for (int i = 0; i < 8192; i++) ref_mem[i] = init_word(i);
      rst_n = 1'b0; wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
      wb_sel = 16'h0000; wb_adr = 12'h000; wb_dat_m = 128'd0;
      repeat (3) @(negedge clk);
      chk({wb_ack, wb_rty, mem_req, mem_we}, 4'h0, "reset_ctl");
      chk({mem_addr, mem_wmask}, 21'd0, "reset_addr_mask");
      chk(mem_wdata, 64'd0, "reset_wdata");
      chk(wb_dat_s, 128'd0, "reset_dat_s");
      rst_n = 1'b1;
      @(negedge clk);

      // Directed transfers.
      run_xfer(1'b0, 12'h0A3, 16'hFFFF, 128'd0, 0, 0, 1, 1'b0, "rd_basic");
      run_xfer(1'b1, 12'h010, 16'hFF00, {$urandom, $urandom, $urandom, $urandom}, 0, 0, 1, 1'b0, "wr_hi_only");
      run_xfer(1'b1, 12'h011, 16'h00FF, {$urandom, $urandom, $urandom, $urandom}, 0, 0, 1, 1'b0, "wr_lo_only");
      run_xfer(1'b1, 12'h012, 16'h0000, {$urandom, $urandom, $urandom, $urandom}, 0, 0, 1, 1'b0, "wr_none");
      run_xfer(1'b1, 12'h013, 16'hFFFF, {$urandom, $urandom, $urandom, $urandom}, 0, 0, 1, 1'b0, "wr_full");
      run_xfer(1'b0, 12'h010, 16'h0000, 128'd0, 0, 0, 1, 1'b0, "rd_after_wr");
      run_xfer(1'b0, 12'h013, 16'h0000, 128'd0, 5, 0, 1, 1'b0, "rd_gnt_stall");
      run_xfer(1'b1, 12'h014, 16'hA5C3, {$urandom, $urandom, $urandom, $urandom}, 5, 2, 1, 1'b0, "wr_gnt_stall");
      run_xfer(1'b0, 12'h014, 16'hFFFF, 128'd0, 0, 3, 1, 1'b0, "rd_early_ret");

      // Back-to-back: read then write with STB held high, then read back.
      run_xfer(1'b0, 12'h020, 16'hFFFF, 128'd0, 0, 0, 1, 1'b1, "b2b_rd");
      run_xfer(1'b1, 12'h020, 16'h3CF0, {$urandom, $urandom, $urandom, $urandom}, 0, 0, 1, 1'b0, "b2b_wr");
      run_xfer(1'b0, 12'h020, 16'hFFFF, 128'd0, 0, 0, 2, 1'b0, "b2b_check");

      // CYC dropped mid-read: both beats still go out, no ACK.
      s0_g = 0; s1_g = 0; lat_g = 1;
      rb0 = rd_seen.size();
      acks = 0;
      wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 12'h031; wb_sel = 16'hFFFF;
      repeat (2) @(negedge clk);
      wb_cyc = 1'b0; wb_stb = 1'b0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (wb_ack === 1'b1) acks++;
      end
      chk(acks, 0, "cyc_drop no_ack");
      chk(rd_seen.size() - rb0, 2, "cyc_drop read_beats");

      // Reset while waiting for read beat 1.
      s0_g = 0; s1_g = 0; lat_g = 3;
      wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 12'h0C1; wb_sel = 16'hFFFF;
      repeat (4) @(negedge clk);
      @(posedge clk);
      #2;
      rst_n = 1'b0; wb_cyc = 1'b0; wb_stb = 1'b0;
      #1;
      chk({wb_ack, mem_req, mem_we}, 3'b000, "async_rst_ctl");
      chk({mem_addr, mem_wmask}, 21'd0, "async_rst_addr_mask");
      chk(mem_wdata, 64'd0, "async_rst_wdata");
      chk(wb_dat_s, 128'd0, "async_rst_dat_s");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_xfer(1'b0, 12'h0C2, 16'hFFFF, 128'd0, 0, 0, 1, 1'b0, "rd_after_rst");

      // Random mix of reads and writes over a few lines.
      for (int t = 0; t < 30; t++) begin
         logic [15:0] sel;
         case ($urandom_range(0, 4))
            0:       sel = 16'h0000;
            1:       sel = 16'hFF00;
            2:       sel = 16'h00FF;
            default: sel = 16'($urandom);
         endcase
         run_xfer(1'($urandom), 12'($urandom_range(0, 7)), sel,
                  {$urandom, $urandom, $urandom, $urandom},
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(1, 3),
                  1'b0, "random");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
